// File: rtl/mips_register_file.sv
`default_nettype none
// ============================================================================
// Module      : mips_register_file
// Description : 32 x 32-bit MIPS general-purpose register file. Two
//               combinational read ports, one synchronous write port, and a
//               debug read port. $zero is hardwired to 0. BYPASS selects
//               optional write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_register_file #(
    parameter bit          BYPASS  = 1'b0,
    parameter logic [31:0] SP_INIT = 32'h0000_0000,
    parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic        we3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  dbg_a,
    output logic [31:0] dbg_rd
);

    localparam logic [4:0] REG_GP = 5'd28;
    localparam logic [4:0] REG_SP = 5'd29;

    // r0 has no storage; only r1..r31 are real registers.
    logic [31:0] regs [1:31];

    logic [31:0] stored_rd1;
    logic [31:0] stored_rd2;
    logic [31:0] stored_dbg;
    logic        write_active;

    // A write only lands when out of reset and not aimed at $zero.
    assign write_active = !reset && we3 && (a3 != 5'd0);

    // Register storage: async reset loads $gp/$sp init values, then one write per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                if (i == int'(REG_GP))
                    regs[i] <= GP_INIT;
                else if (i == int'(REG_SP))
                    regs[i] <= SP_INIT;
                else
                    regs[i] <= 32'h0;
            end
        end else if (we3 && (a3 != 5'd0)) begin
            regs[a3] <= wd3;
        end
    end

    // Combinational reads of the stored array; address 0 always reads zero.
    always_comb begin
        stored_rd1 = 32'h0;
        stored_rd2 = 32'h0;
        stored_dbg = 32'h0;
        if (a1 != 5'd0)
            stored_rd1 = regs[a1];
        if (a2 != 5'd0)
            stored_rd2 = regs[a2];
        if (dbg_a != 5'd0)
            stored_dbg = regs[dbg_a];
    end

    generate
        if (BYPASS) begin : g_bypass
            // Forward the in-flight write data to any port reading the target register.
            always_comb begin
                rd1    = (write_active && (a1    == a3)) ? wd3 : stored_rd1;
                rd2    = (write_active && (a2    == a3)) ? wd3 : stored_rd2;
                dbg_rd = (write_active && (dbg_a == a3)) ? wd3 : stored_dbg;
            end
        end else begin : g_no_bypass
            // Reads see only committed state; a same-cycle write appears after the edge.
            always_comb begin
                rd1    = stored_rd1;
                rd2    = stored_rd2;
                dbg_rd = stored_dbg;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mips_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_register_file
// Description : Scoreboard bench for mips_register_file. Stimulus drives the
//               ports just after each rising edge and queues the expected
//               read-port values; a monitor compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_register_file;

    localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_VAL = 32'h1000_8000;

    localparam int P_RD1 = 0;
    localparam int P_RD2 = 1;
    localparam int P_DBG = 2;

    logic        clk;
    logic        reset;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  dbg_a;
    logic [31:0] dbg_rd;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total;
    int   checks_passed;

    mips_register_file #(
        .BYPASS  (1'b0),
        .SP_INIT (SP_VAL),
        .GP_INIT (GP_VAL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .we3    (we3),
        .wd3    (wd3),
        .rd1    (rd1),
        .rd2    (rd2),
        .dbg_a  (dbg_a),
        .dbg_rd (dbg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each falling edge, drain and check every queued expectation.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.port)
                P_RD1:   act = rd1;
                P_RD2:   act = rd2;
                default: act = dbg_rd;
            endcase
            checks_total++;
            if (act === e.exp)
                checks_passed++;
            else
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.port = port;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_cycles;
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b1;
        a1 = '0; a2 = '0; a3 = '0; we3 = 1'b0; wd3 = '0; dbg_a = '0;

        // 1: reset values
        step();
        dbg_a = 5'd29; expect_val("reset_sp", P_DBG, SP_VAL);
        a1 = 5'd28;    expect_val("reset_gp", P_RD1, GP_VAL);
        a2 = 5'd5;     expect_val("reset_r5", P_RD2, 32'h0);
        step();
        dbg_a = 5'd0;  expect_val("reset_r0", P_DBG, 32'h0);
        a1 = 5'd5;     expect_val("reset_r5_rd1", P_RD1, 32'h0);
        step();
        reset = 1'b0;

        // 2: write / read
        we3 = 1'b1; a3 = 5'd8; wd3 = 32'hDEAD_BEEF;
        step();
        we3 = 1'b0; a1 = 5'd8; a2 = 5'd8; dbg_a = 5'd8;
        expect_val("wr_rd1", P_RD1, 32'hDEAD_BEEF);
        expect_val("wr_rd2", P_RD2, 32'hDEAD_BEEF);
        expect_val("wr_dbg", P_DBG, 32'hDEAD_BEEF);

        // 3: writes to $zero are dropped
        step();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234_5678; a1 = 5'd0;
        expect_val("zero_before", P_RD1, 32'h0);
        step();
        we3 = 1'b0; a1 = 5'd0; dbg_a = 5'd0;
        expect_val("zero_rd1", P_RD1, 32'h0);
        expect_val("zero_dbg", P_DBG, 32'h0);

        // 4: same-cycle read/write, no forwarding
        step();
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'd5;
        step();
        a1 = 5'd9; a3 = 5'd9; wd3 = 32'd7; we3 = 1'b1;
        expect_val("raw_old", P_RD1, 32'd5);
        step();
        we3 = 1'b0;
        expect_val("raw_new", P_RD1, 32'd7);

        // 5: async reset mid-operation
        step();
        we3 = 1'b1; a3 = 5'd10; wd3 = 32'hA5A5_A5A5;
        step();
        we3 = 1'b0; a1 = 5'd10;
        expect_val("r10_written", P_RD1, 32'hA5A5_A5A5);
        step();
        reset = 1'b1; we3 = 1'b1; a3 = 5'd10; wd3 = 32'd1;
        dbg_a = 5'd29; a2 = 5'd8;
        expect_val("areset_r10", P_RD1, 32'h0);
        expect_val("areset_sp",  P_DBG, SP_VAL);
        expect_val("areset_r8",  P_RD2, 32'h0);
        step();
        expect_val("reset_blocks_wr", P_RD1, 32'h0);
        // release mid-cycle with a write pending: it lands on the next edge
        step();
        reset = 1'b0; we3 = 1'b1; a3 = 5'd11; wd3 = 32'h55; a1 = 5'd11; a2 = 5'd10;
        expect_val("release_r10", P_RD2, 32'h0);
        expect_val("release_before", P_RD1, 32'h0);
        step();
        we3 = 1'b0;
        expect_val("release_after", P_RD1, 32'h55);

        // 6: sweep write r1..r31, then read back on all ports
        for (int n = 1; n < 32; n++) begin
            step();
            we3 = 1'b1; a3 = 5'(n); wd3 = 32'h100 + 32'(n);
        end
        step();
        we3 = 1'b0;
        for (int n = 0; n < 32; n++) begin
            int m;
            m = 31 - n;
            step();
            a1 = 5'(n); a2 = 5'(m); dbg_a = 5'(n);
            expect_val($sformatf("sweep_rd1_r%0d", n), P_RD1, (n == 0) ? 32'h0 : 32'h100 + 32'(n));
            expect_val($sformatf("sweep_rd2_r%0d", m), P_RD2, (m == 0) ? 32'h0 : 32'h100 + 32'(m));
            expect_val($sformatf("sweep_dbg_r%0d", n), P_DBG, (n == 0) ? 32'h0 : 32'h100 + 32'(n));
        end

        // drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        #1;
        if (exp_q.size() > 0) begin
            checks_total++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
